// File: rtl/dmac_pkg.sv
// Shared definitions for the multi-channel DMA master.
//   state_t      : engine FSM states
//   SRC_INC, DEST_INC, FILL_ZERO : bit positions inside a channel's 3-bit op_mode
//   DEF_*        : default parameter values used by dmac_master_mc and its interface
package dmac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        BUS_REQ,
        MEM_READ,
        MEM_WRITE
    } state_t;

    localparam int SRC_INC   = 0;
    localparam int DEST_INC  = 1;
    localparam int FILL_ZERO = 2;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_SIZE_W    = 16;
    localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/dmac_master_mc_if.sv
// Memory bus between the DMA master and the memory/arbiter side.
//   M_req     : bus request (master -> slave)
//   M_grant   : bus grant (slave -> master)
//   M_wr      : write strobe (master -> slave)
//   M_address : address of the current read or write (master -> slave)
//   M_dout    : write data (master -> slave)
//   M_din     : read data, valid one cycle after the read address (slave -> master)
interface dmac_master_mc_if
    import dmac_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              M_req;
    logic              M_grant;
    logic              M_wr;
    logic [ADDR_W-1:0] M_address;
    logic [DATA_W-1:0] M_dout;
    logic [DATA_W-1:0] M_din;

    modport master (
        output M_req, M_wr, M_address, M_dout,
        input  M_grant, M_din
    );

    modport slave (
        input  M_req, M_wr, M_address, M_dout,
        output M_grant, M_din
    );
endinterface

// File: rtl/dmac_rr_arbiter.sv
// Round-robin channel arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req        : per-channel request (eligible channels)
//   advance    : pulse when the current grant is taken; the priority pointer
//                then moves to the channel after the granted one
//   grant      : one-hot, first requesting channel at or after the pointer
// The pointer holds the channel with highest priority; reset points it at 0.
module dmac_rr_arbiter
    import dmac_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant
);
    localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic          found;

    // Outer loop walks priority order starting at ptr; inner loop finds the
    // channel with that rank so every index stays a constant.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        ptr_nxt = ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + i) % NUM_CH))) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                    ptr_nxt  = PW'((j + 1) % NUM_CH);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= ptr_nxt;
        end
    end
endmodule

// File: rtl/dmac_master_mc.sv
// Multi-channel DMA master: copies descriptors (src, dest, word count) taken
// from per-channel show-ahead FIFOs over a single request/grant memory bus,
// one read followed by one write per word.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   bus          : memory bus (master modport of dmac_master_mc_if)
//   op_start     : per-channel start pulse (arms an idle, not-done channel)
//   op_clear     : per-channel done clear (wins over op_start)
//   op_mode      : per-channel {fill_zero, dest_inc_alt, src_inc}, live
//   op_done      : per-channel done flag, held until op_clear
//   desc_valid   : per-channel FIFO non-empty
//   rd_en        : one-hot FIFO pop
//   src_addr, dest_addr, data_size : per-channel FIFO heads
//   busy         : engine not idle
//   active_ch    : channel currently owning the engine
// Build option: define DMAC_MASTER_PREEMPT_EN to give every channel a saved
// context so a channel yields after BURST_LEN words when another one waits.
module dmac_master_mc
    import dmac_pkg::*;
#(
    parameter int  NUM_CH    = DEF_NUM_CH,
    parameter int  ADDR_W    = DEF_ADDR_W,
    parameter int  DATA_W    = DEF_DATA_W,
    parameter int  SIZE_W    = DEF_SIZE_W,
    parameter int  BURST_LEN = DEF_BURST_LEN,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    dmac_master_mc_if.master         bus,
    input  logic [NUM_CH-1:0]        op_start,
    input  logic [NUM_CH-1:0]        op_clear,
    input  logic [3*NUM_CH-1:0]      op_mode,
    output logic [NUM_CH-1:0]        op_done,
    input  logic [NUM_CH-1:0]        desc_valid,
    output logic [NUM_CH-1:0]        rd_en,
    input  logic [NUM_CH*ADDR_W-1:0] src_addr,
    input  logic [NUM_CH*ADDR_W-1:0] dest_addr,
    input  logic [NUM_CH*SIZE_W-1:0] data_size,
    output logic                     busy,
    output logic [CH_W-1:0]          active_ch
);
    if (NUM_CH < 1 || NUM_CH > 8 || BURST_LEN < 1) begin : g_bad_param
        $error("dmac_master_mc: NUM_CH must be 1..8 and BURST_LEN at least 1");
    end

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   armed;
    logic [NUM_CH-1:0]   elig;
    logic [NUM_CH-1:0]   grant;
    logic [NUM_CH-1:0]   cur_oh;
    logic [NUM_CH-1:0]   ctx_valid;
    logic [CH_W-1:0]     cur_ch;
    logic [CH_W-1:0]     gidx;
    logic                advance;
    logic                preempt;
    logic [2:0]          mode;
    logic [ADDR_W-1:0]   cur_src;
    logic [ADDR_W-1:0]   cur_dest;
    logic [ADDR_W-1:0]   src_nxt;
    logic [ADDR_W-1:0]   dest_nxt;
    logic [ADDR_W-1:0]   head_src;
    logic [ADDR_W-1:0]   head_dest;
    logic [SIZE_W-1:0]   head_size;
    logic [SIZE_W-1:0]   remaining;
    logic [SIZE_W-1:0]   rem_dec;

    assign busy      = (state != IDLE);
    assign active_ch = cur_ch;
    assign elig      = armed & (desc_valid | ctx_valid);

    // Per-channel selects; op_mode is read live for the owning channel.
    always_comb begin
        cur_oh    = '0;
        mode      = '0;
        head_src  = '0;
        head_dest = '0;
        head_size = '0;
        gidx      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cur_ch == CH_W'(c)) begin
                cur_oh[c] = 1'b1;
                mode      = op_mode[3*c +: 3];
                head_src  = src_addr[c*ADDR_W +: ADDR_W];
                head_dest = dest_addr[c*ADDR_W +: ADDR_W];
                head_size = data_size[c*SIZE_W +: SIZE_W];
            end
            if (grant[c]) begin
                gidx = CH_W'(c);
            end
        end
    end

    // Address arithmetic wraps silently at 2^ADDR_W.
    assign rem_dec  = remaining - SIZE_W'(1);
    assign src_nxt  = mode[SRC_INC] ? cur_src + ADDR_W'(1) : cur_src;
    assign dest_nxt = (mode[DEST_INC] || mode[FILL_ZERO]) ? cur_dest + ADDR_W'(1) : cur_dest;

    dmac_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (elig),
        .advance (advance),
        .grant   (grant)
    );

    always_comb begin
        state_nxt     = state;
        rd_en         = '0;
        advance       = 1'b0;
        bus.M_req     = 1'b0;
        bus.M_wr      = 1'b0;
        bus.M_address = '0;
        bus.M_dout    = '0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    advance   = 1'b1;
                    state_nxt = (|(grant & ctx_valid)) ? BUS_REQ : POP;
                end
            end
            POP: begin
                rd_en     = cur_oh;
                state_nxt = (head_size == '0) ? IDLE : BUS_REQ;
            end
            BUS_REQ: begin
                bus.M_req = 1'b1;
                if (bus.M_grant) begin
                    state_nxt = MEM_READ;
                end
            end
            MEM_READ: begin
                bus.M_req     = 1'b1;
                bus.M_address = cur_src;
                state_nxt     = MEM_WRITE;
            end
            MEM_WRITE: begin
                bus.M_req     = 1'b1;
                bus.M_wr      = 1'b1;
                bus.M_address = cur_dest;
                bus.M_dout    = mode[FILL_ZERO] ? DATA_W'(0) : bus.M_din;
                if (rem_dec == '0 || preempt) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = MEM_READ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, owner, armed/done flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cur_ch  <= '0;
            armed   <= '0;
            op_done <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && |grant) begin
                cur_ch <= gidx;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                if (op_clear[c]) begin
                    op_done[c] <= 1'b0;
                end else if (op_start[c] && !armed[c] && !op_done[c]) begin
                    armed[c] <= 1'b1;
                end
                // Armed with nothing left to move and not owning the engine:
                // finished. Cannot coincide with the branches above, since a
                // done channel is never armed.
                if (armed[c] && !desc_valid[c] && !ctx_valid[c] && !(busy && cur_oh[c])) begin
                    op_done[c] <= 1'b1;
                    armed[c]   <= 1'b0;
                end
            end
        end
    end

`ifdef DMAC_MASTER_PREEMPT_EN
    localparam int BW = $clog2(BURST_LEN + 1);

    logic [BW-1:0]     burst_cnt;
    logic [ADDR_W-1:0] ctx_src  [NUM_CH];
    logic [ADDR_W-1:0] ctx_dest [NUM_CH];
    logic [SIZE_W-1:0] ctx_rem  [NUM_CH];

    // burst_cnt counts MEM_WRITEs already completed in this grant; it
    // saturates so a long unopposed run still yields as soon as a rival appears.
    assign preempt = (burst_cnt >= BW'(BURST_LEN - 1)) && |(elig & ~cur_oh);

    always_ff @(posedge clk) begin
        if (reset) begin
            burst_cnt <= '0;
            ctx_valid <= '0;
        end else begin
            if (state == BUS_REQ) begin
                burst_cnt <= '0;
            end else if (state == MEM_WRITE && burst_cnt != BW'(BURST_LEN)) begin
                burst_cnt <= burst_cnt + BW'(1);
            end
            if (state == IDLE) begin
                ctx_valid <= ctx_valid & ~grant;
            end else if (state == MEM_WRITE && rem_dec != '0 && preempt) begin
                ctx_valid <= ctx_valid | cur_oh;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == MEM_WRITE && rem_dec != '0 && preempt) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cur_oh[c]) begin
                    ctx_src[c]  <= src_nxt;
                    ctx_dest[c] <= dest_nxt;
                    ctx_rem[c]  <= rem_dec;
                end
            end
        end
    end
`else
    assign ctx_valid = '0;
    assign preempt   = 1'b0;
`endif

    // Working registers of the owning channel.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
`ifdef DMAC_MASTER_PREEMPT_EN
                for (int c = 0; c < NUM_CH; c++) begin
                    if (grant[c] && ctx_valid[c]) begin
                        cur_src   <= ctx_src[c];
                        cur_dest  <= ctx_dest[c];
                        remaining <= ctx_rem[c];
                    end
                end
`endif
            end
            POP: begin
                cur_src   <= head_src;
                cur_dest  <= head_dest;
                remaining <= head_size;
            end
            MEM_WRITE: begin
                cur_src   <= src_nxt;
                cur_dest  <= dest_nxt;
                remaining <= rem_dec;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_dmac_master_mc.sv
// Directed testbench for dmac_master_mc (2 channels, 8-bit addresses).
// Memory returns {24'hC0FFEE, address} one cycle after the read address.
module tb_dmac_master_mc;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int SIZE_W = 16;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        op_start;
    logic [NUM_CH-1:0]        op_clear;
    logic [3*NUM_CH-1:0]      op_mode;
    logic [NUM_CH-1:0]        op_done;
    logic [NUM_CH-1:0]        desc_valid;
    logic [NUM_CH-1:0]        rd_en;
    logic [NUM_CH*ADDR_W-1:0] src_addr;
    logic [NUM_CH*ADDR_W-1:0] dest_addr;
    logic [NUM_CH*SIZE_W-1:0] data_size;
    logic                     busy;
    logic [0:0]               active_ch;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmac_master_mc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmac_master_mc #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .BURST_LEN(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .op_start   (op_start),
        .op_clear   (op_clear),
        .op_mode    (op_mode),
        .op_done    (op_done),
        .desc_valid (desc_valid),
        .rd_en      (rd_en),
        .src_addr   (src_addr),
        .dest_addr  (dest_addr),
        .data_size  (data_size),
        .busy       (busy),
        .active_ch  (active_ch)
    );

    // Memory model
    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {24'hC0FFEE, a};
    endfunction

    always @(posedge clk) bus.M_din <= mem_word(bus.M_address);

    // Descriptor FIFO model, show-ahead
    logic [7:0]  f_src  [2][16];
    logic [7:0]  f_dest [2][16];
    logic [15:0] f_size [2][16];
    logic [3:0]  wp [2];
    logic [3:0]  rp [2] = '{4'd0, 4'd0};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
        assign desc_valid[c]           = (wp[c] != rp[c]);
        assign src_addr[c*8 +: 8]      = f_src[c][rp[c]];
        assign dest_addr[c*8 +: 8]     = f_dest[c][rp[c]];
        assign data_size[c*16 +: 16]   = f_size[c][rp[c]];
    end

    always @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_en[c]) rp[c] <= rp[c] + 4'd1;
        end
    end

    // Bus logger: each write also records the read address of the cycle before
    int         n_wr  = 0;
    int         n_req = 0;
    int         n_pop = 0;
    logic [7:0] prev_addr = 8'h00;
    logic [7:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [7:0] wr_src  [64];

    always @(posedge clk) begin
        if (!reset) begin
            if (bus.M_req) n_req++;
            n_pop += $countones(rd_en);
            if (bus.M_req && bus.M_wr && n_wr < 64) begin
                wr_addr[n_wr] = bus.M_address;
                wr_data[n_wr] = bus.M_dout;
                wr_src[n_wr]  = prev_addr;
                n_wr++;
            end
        end
        prev_addr = bus.M_address;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [7:0] s, input logic [7:0] d, input logic [15:0] n);
        f_src[c][wp[c]]  = s;
        f_dest[c][wp[c]] = d;
        f_size[c][wp[c]] = n;
        wp[c] = wp[c] + 4'd1;
    endtask

    task automatic set_mode(input int c, input logic [2:0] m);
        op_mode[3*c +: 3] = m;
    endtask

    task automatic start(input logic [1:0] m);
        op_start = m;
        @(negedge clk);
        op_start = '0;
    endtask

    task automatic clear(input logic [1:0] m);
        op_clear = m;
        @(negedge clk);
        op_clear = '0;
    endtask

    task automatic wait_done(input string tag, input logic [1:0] m, input int budget);
        int k;
        k = 0;
        while (((op_done & m) != m) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(op_done & m), 32'(m));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, rb, pb, k;
        logic [7:0] exp_a [12];
        logic [7:0] exp_s [12];
        int exp_req;

        reset    = 1'b1;
        op_start = '0;
        op_clear = '0;
        op_mode  = '0;
        wp[0]    = 4'd0;
        wp[1]    = 4'd0;
        bus.M_grant = 1'b1;
        cyc(3);

        // Reset state
        check_eq("rst_done",   32'(op_done), 0);
        check_eq("rst_busy",   32'(busy), 0);
        check_eq("rst_req",    32'(bus.M_req), 0);
        check_eq("rst_rd_en",  32'(rd_en), 0);
        check_eq("rst_active", 32'(active_ch), 0);
        reset = 1'b0;
        cyc(1);

        // Basic copy, src increments, dest fixed
        set_mode(0, 3'b001);
        push(0, 8'h10, 8'h40, 16'd3);
        wb = n_wr; rb = n_req; pb = n_pop;
        start(2'b01);
        wait_done("t1_done", 2'b01, 100);
        check_eq("t1_nwr", 32'(n_wr - wb), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq("t1_waddr", 32'(wr_addr[wb+i]), 32'h40);
            check_eq("t1_wdata", wr_data[wb+i], 32'hC0FFEE10 + 32'(i));
            check_eq("t1_raddr", 32'(wr_src[wb+i]), 32'h10 + 32'(i));
        end
        check_eq("t1_req_cycles", 32'(n_req - rb), 7);
        check_eq("t1_pops", 32'(n_pop - pb), 1);
        check_eq("t1_busy", 32'(busy), 0);
        clear(2'b01);
        check_eq("t1_clear", 32'(op_done), 0);

        // Fill zero with dest wrap on ch1, grant withheld at first
        set_mode(1, 3'b110);
        push(1, 8'h20, 8'hFE, 16'd3);
        wb = n_wr;
        bus.M_grant = 1'b0;
        start(2'b10);
        cyc(6);
        check_eq("t2_wait_grant_busy", 32'(busy), 1);
        check_eq("t2_wait_grant_req", 32'(bus.M_req), 1);
        check_eq("t2_wait_grant_nwr", 32'(n_wr - wb), 0);
        bus.M_grant = 1'b1;
        wait_done("t2_done", 2'b10, 100);
        check_eq("t2_nwr", 32'(n_wr - wb), 3);
        check_eq("t2_waddr0", 32'(wr_addr[wb]),   32'hFE);
        check_eq("t2_waddr1", 32'(wr_addr[wb+1]), 32'hFF);
        check_eq("t2_waddr2", 32'(wr_addr[wb+2]), 32'h00);
        for (int i = 0; i < 3; i++) begin
            check_eq("t2_wdata", wr_data[wb+i], 32'h0);
            check_eq("t2_raddr", 32'(wr_src[wb+i]), 32'h20);
        end
        clear(2'b10);

        // Two channels, round robin
        set_mode(0, 3'b011);
        set_mode(1, 3'b011);
        push(0, 8'h30, 8'h50, 16'd2);
        push(1, 8'h60, 8'h70, 16'd2);
        wb = n_wr;
        start(2'b11);
        wait_done("t3_done", 2'b11, 200);
        check_eq("t3_nwr", 32'(n_wr - wb), 4);
        check_eq("t3_waddr0", 32'(wr_addr[wb]),   32'h50);
        check_eq("t3_waddr1", 32'(wr_addr[wb+1]), 32'h51);
        check_eq("t3_waddr2", 32'(wr_addr[wb+2]), 32'h70);
        check_eq("t3_waddr3", 32'(wr_addr[wb+3]), 32'h71);
        check_eq("t3_wdata1", wr_data[wb+1], 32'hC0FFEE31);
        check_eq("t3_wdata2", wr_data[wb+2], 32'hC0FFEE60);
        clear(2'b11);
        push(0, 8'h34, 8'h54, 16'd1);
        push(1, 8'h64, 8'h74, 16'd1);
        wb = n_wr;
        start(2'b11);
        wait_done("t3b_done", 2'b11, 200);
        check_eq("t3b_first", 32'(wr_addr[wb]),   32'h54);
        check_eq("t3b_second", 32'(wr_addr[wb+1]), 32'h74);
        clear(2'b11);

        // Size-0 descriptor then empty FIFO
        set_mode(0, 3'b001);
        push(0, 8'h11, 8'h22, 16'd0);
        wb = n_wr; rb = n_req; pb = n_pop;
        start(2'b01);
        wait_done("t4_done", 2'b01, 50);
        check_eq("t4_pops", 32'(n_pop - pb), 1);
        check_eq("t4_req_cycles", 32'(n_req - rb), 0);
        check_eq("t4_nwr", 32'(n_wr - wb), 0);

        // Start ignored while done; clear beats start
        push(0, 8'h20, 8'h28, 16'd1);
        pb = n_pop;
        start(2'b01);
        cyc(6);
        check_eq("t5_start_ignored_busy", 32'(busy), 0);
        check_eq("t5_start_ignored_pop", 32'(n_pop - pb), 0);
        check_eq("t5_done_held", 32'(op_done), 1);
        op_clear = 2'b01;
        op_start = 2'b01;
        @(negedge clk);
        op_clear = '0;
        op_start = '0;
        check_eq("t5_clear_wins_done", 32'(op_done), 0);
        cyc(5);
        check_eq("t5_clear_wins_pop", 32'(n_pop - pb), 0);
        wb = n_wr;
        start(2'b01);
        wait_done("t5_done", 2'b01, 50);
        check_eq("t5_nwr", 32'(n_wr - wb), 1);
        check_eq("t5_waddr", 32'(wr_addr[wb]), 32'h28);
        check_eq("t5_wdata", wr_data[wb], 32'hC0FFEE20);
        clear(2'b01);

        // Reset during the second write of five
        set_mode(0, 3'b011);
        push(0, 8'h80, 8'h90, 16'd5);
        wb = n_wr;
        start(2'b01);
        k = 0;
        while (!(bus.M_wr && n_wr == wb + 1) && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq("t6_reach_write2", 32'(bus.M_wr), 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("t6_req",    32'(bus.M_req), 0);
        check_eq("t6_wr",     32'(bus.M_wr), 0);
        check_eq("t6_addr",   32'(bus.M_address), 0);
        check_eq("t6_dout",   bus.M_dout, 0);
        check_eq("t6_rd_en",  32'(rd_en), 0);
        check_eq("t6_busy",   32'(busy), 0);
        check_eq("t6_done",   32'(op_done), 0);
        check_eq("t6_active", 32'(active_ch), 0);
        reset = 1'b0;
        cyc(1);
        push(0, 8'hA0, 8'hB0, 16'd2);
        wb = n_wr;
        start(2'b01);
        wait_done("t6_restart_done", 2'b01, 100);
        check_eq("t6_nwr", 32'(n_wr - wb), 2);
        check_eq("t6_waddr0", 32'(wr_addr[wb]),   32'hB0);
        check_eq("t6_waddr1", 32'(wr_addr[wb+1]), 32'hB1);
        check_eq("t6_wdata1", wr_data[wb+1], 32'hC0FFEEA1);
        clear(2'b01);

        // Long ch0 descriptor against a short ch1 one
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        cyc(1);
`ifdef DMAC_MASTER_PREEMPT_EN
        exp_a   = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD0, 8'hD1,
                    8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9};
        exp_s   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'hE0, 8'hE1,
                    8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        exp_req = 27;
`else
        exp_a   = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5,
                    8'hC6, 8'hC7, 8'hC8, 8'hC9, 8'hD0, 8'hD1};
        exp_s   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                    8'h06, 8'h07, 8'h08, 8'h09, 8'hE0, 8'hE1};
        exp_req = 26;
`endif
        push(0, 8'h00, 8'hC0, 16'd10);
        push(1, 8'hE0, 8'hD0, 16'd2);
        wb = n_wr; rb = n_req; pb = n_pop;
        start(2'b11);
        wait_done("t7_done", 2'b11, 400);
        check_eq("t7_nwr", 32'(n_wr - wb), 12);
        check_eq("t7_req_cycles", 32'(n_req - rb), 32'(exp_req));
        check_eq("t7_pops", 32'(n_pop - pb), 2);
        for (int i = 0; i < 12; i++) begin
            check_eq("t7_waddr", 32'(wr_addr[wb+i]), 32'(exp_a[i]));
            check_eq("t7_wdata", wr_data[wb+i], {24'hC0FFEE, exp_s[i]});
        end
        clear(2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dmac_master_mc.md
DMAC_MASTER_MC -- requirements
Module: dmac_master_mc

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent DMA channels (1..8).
REQ-002 Parameter ADDR_W, default 8, bus address width.
REQ-003 Parameter DATA_W, default 32, bus data width.
REQ-004 Parameter SIZE_W, default 16, descriptor word-count width.
REQ-005 Parameter BURST_LEN, default 4, words per grant before yielding (preemption only).
REQ-006 The block SHALL have one clock; reset is synchronous and active-high. Ports are clk (input, 1, rising-edge clock) and reset (input, 1, synchronous active-high reset).
REQ-007 M_req out 1 bus request; M_grant in 1 bus grant; M_wr out 1 write strobe; M_address out ADDR_W; M_dout out DATA_W; M_din in DATA_W, read data valid one cycle after the read address.
REQ-008 op_start in NUM_CH, per-channel start pulse; op_clear in NUM_CH, per-channel done clear; op_mode in 3*NUM_CH, per-channel {fill_zero, dest_inc_alt, src_inc}; op_done out NUM_CH.
REQ-009 desc_valid in NUM_CH, per-channel FIFO non-empty; rd_en out NUM_CH, one-hot pop; src_addr in NUM_CH*ADDR_W; dest_addr in NUM_CH*ADDR_W; data_size in NUM_CH*SIZE_W; all show-ahead FIFO heads.
REQ-010 busy out 1, high when not IDLE; active_ch out $clog2(NUM_CH) (min 1), the channel currently owning the engine.

Function
REQ-011 The FSM SHALL have states IDLE, POP, BUS_REQ, MEM_READ, MEM_WRITE.
REQ-012 op_start[c] SHALL arm channel c only if it is neither armed nor done; otherwise it is ignored.
REQ-013 Channel c is eligible when armed and (desc_valid[c] or saved context with remaining>0).
REQ-014 IDLE: each cycle, the round-robin arbiter SHALL pick the first eligible channel after the last served; with saved context -> BUS_REQ, else -> POP; none eligible -> stay IDLE.
REQ-015 POP: rd_en[c]=1 for exactly one cycle; src, dest and size latched at that edge; size==0 -> IDLE (descriptor discarded), else -> BUS_REQ.
REQ-016 BUS_REQ: M_req=1; M_grant=1 -> MEM_READ, else stay; M_grant is sampled only in this state.
REQ-017 MEM_READ: M_req=1, M_wr=0, M_address=src; always -> MEM_WRITE.
REQ-018 MEM_WRITE: M_req=1, M_wr=1, M_address=dest, M_dout=0 when fill_zero, else M_din; remaining decrements by 1; src increments if src_inc; dest increments if dest_inc_alt or fill_zero.
REQ-019 Address arithmetic SHALL wrap modulo 2^ADDR_W, with no flag.
REQ-020 After MEM_WRITE: remaining==0 -> IDLE; else -> MEM_READ (subject to REQ-030).
REQ-021 Outside BUS_REQ, MEM_READ and MEM_WRITE: M_req, M_wr, M_address and M_dout SHALL be 0.
REQ-022 An armed channel that has no desc_valid, no saved context and is not active SHALL set op_done[c] on the next edge and clear armed.
REQ-023 op_done[c] SHALL hold until op_clear[c]; op_clear on a non-done channel has no effect.
REQ-024 When op_clear[c] and op_start[c] coincide, op_clear SHALL win and op_start is ignored that cycle.
REQ-025 op_mode[c] SHALL be sampled every cycle of the transfer, not latched.

Reset
REQ-026 On reset, the FSM SHALL go to IDLE and all outputs to 0; armed, done, saved contexts and arbiter pointer (to channel 0) clear; an in-flight word is abandoned.
REQ-027 Reset SHALL take precedence over every other input in the same cycle.

Configuration
REQ-028 With macro DMAC_MASTER_PREEMPT_EN defined, each channel SHALL keep a saved context {src, dest, remaining}.
REQ-029 Without DMAC_MASTER_PREEMPT_EN, a channel SHALL hold the engine until its descriptor completes, and no context storage is built.
REQ-030 With DMAC_MASTER_PREEMPT_EN: after BURST_LEN consecutive MEM_WRITEs with remaining>0 and another channel eligible, the block SHALL save context and go to IDLE (M_req drops one cycle); the burst counter resets on every BUS_REQ entry.

Structure
REQ-031 Package dmac_pkg SHALL hold the state enum, the op_mode bit-index constants (SRC_INC=0, DEST_INC=1, FILL_ZERO=2) and the default parameter values.
REQ-032 Round-robin selection SHALL be the sub-module dmac_rr_arbiter (req NUM_CH, grant one-hot, advance pulse).

Verification
REQ-033 Ch0 mode 001, src 0x10, dest 0x40, size 3, grant held: reads 0x10/0x11/0x12 and writes 0x40 x3; then op_done[0]; total 1 POP + 1 BUS_REQ + 6 bus cycles.
REQ-034 Mode 110, dest 0xFE, size 3: writes data 0 to 0xFE, 0xFF, 0x00 (wrap).
REQ-035 Ch0 and ch1 both armed, each with 1 descriptor of size 2: ch0 served fully, then ch1; op_done for both; next pick is ch0.
REQ-036 PREEMPT_EN, BURST_LEN=4, ch0 size 10, ch1 size 2: ch0 4 words, ch1 2 words, ch0 remaining 6 resumes at src+4.
REQ-037 Size-0 descriptor followed by empty FIFO: rd_en one pulse, no bus cycle, op_done set.
REQ-038 Reset asserted in MEM_WRITE of word 2 of 5: next cycle all outputs 0 and IDLE; a fresh op_start restarts cleanly.
